// File: rtl/mouse_pkg.sv
//============================================================================
// Module      : mouse_pkg
// Description : Shared state codes, PS/2 command bytes and mouse response
//               bytes for the host-side PS/2 mouse protocol controller.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mouse_pkg;

    // State codes, as reported on CURR_STATE
    localparam logic [3:0] ST_INIT          = 4'd0;
    localparam logic [3:0] ST_SEND_RST      = 4'd1;
    localparam logic [3:0] ST_WAIT_RST_SENT = 4'd2;
    localparam logic [3:0] ST_WAIT_ACK1     = 4'd3;
    localparam logic [3:0] ST_WAIT_SELFTEST = 4'd4;
    localparam logic [3:0] ST_WAIT_ID       = 4'd5;
    localparam logic [3:0] ST_SEND_EN       = 4'd6;
    localparam logic [3:0] ST_WAIT_EN_SENT  = 4'd7;
    localparam logic [3:0] ST_WAIT_ACK2     = 4'd8;
    localparam logic [3:0] ST_RD_STATUS     = 4'd9;
    localparam logic [3:0] ST_RD_DX         = 4'd10;
    localparam logic [3:0] ST_RD_DY         = 4'd11;
    localparam logic [3:0] ST_PUBLISH       = 4'd12;

    // Host-to-mouse commands
    localparam logic [7:0] CMD_RESET        = 8'hFF;
    localparam logic [7:0] CMD_STREAM_EN    = 8'hF4;

    // Mouse-to-host responses
    localparam logic [7:0] RSP_ACK          = 8'hFA;
    localparam logic [7:0] RSP_SELFTEST_OK  = 8'hAA;
    localparam logic [7:0] RSP_DEV_ID       = 8'h00;

    // States in which the receiver is enabled and BYTE_READY is honoured
    function automatic logic is_read_state(input logic [3:0] s);
        return (s == ST_WAIT_ACK1)     || (s == ST_WAIT_SELFTEST) ||
               (s == ST_WAIT_ID)       || (s == ST_WAIT_ACK2)     ||
               (s == ST_RD_STATUS)     || (s == ST_RD_DX)         ||
               (s == ST_RD_DY);
    endfunction

    // States in which the mouse is expected to answer (watchdog supervised)
    function automatic logic is_watchdog_state(input logic [3:0] s);
        return ((s >= ST_WAIT_RST_SENT) && (s <= ST_WAIT_ID)) ||
               ((s >= ST_WAIT_EN_SENT)  && (s <= ST_RD_DY));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mouse_sm_timer.sv
//============================================================================
// Module      : mouse_sm_timer
// Description : Loadable up-counter with a terminal-count flag. Used by the
//               mouse controller for the power-up wait and the watchdog.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load/i_load_val - load the counter (priority over i_en)
//               i_en            - count enable
//               i_terminal      - terminal value compared against the count
//               o_tc            - count equals i_terminal
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mouse_sm_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_terminal,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_terminal);

endmodule

`default_nettype wire

// File: rtl/mouse_master_sm.sv
//============================================================================
// Module      : mouse_master_sm
// Description : Host-side PS/2 mouse protocol controller. Runs the reset /
//               stream-enable handshake, then collects 3-byte movement
//               packets and publishes them with a one-cycle interrupt.
// Ports       : CLK, RESET                - clock, sync active-high reset
//               SEND_BYTE, BYTE_TO_SEND   - transmitter request / command
//               BYTE_SENT                 - transmitter done pulse
//               READ_ENABLE               - receiver enable
//               BYTE_READ, BYTE_ERROR_CODE, BYTE_READY - receiver result
//               MOUSE_STATUS/DX/DY        - last complete packet
//               SEND_INTERRUPT            - new packet pulse
//               CURR_STATE                - state code for debug
// Config      : MOUSE_SM_WATCHDOG_EN - enables the response watchdog
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mouse_master_sm
    import mouse_pkg::*;
#(
    parameter int unsigned INIT_WAIT_CYCLES = 5_000_000,
    parameter int unsigned WATCHDOG_CYCLES  = 10_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT,
    output logic [3:0] CURR_STATE
);

    localparam logic [31:0] c_init_tc = 32'(INIT_WAIT_CYCLES - 1);
    localparam logic [31:0] c_wd_tc   = 32'(WATCHDOG_CYCLES - 1);

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic        w_accept;
    logic        w_bad;
    logic        w_tc;
    logic        w_wd_active;
    logic        w_count_en;
    logic        w_clear;
    logic [31:0] w_terminal;

    logic        r_send_byte;
    logic [7:0]  r_byte_to_send;
    logic        r_read_en;
    logic [7:0]  r_sh_status;
    logic [7:0]  r_sh_dx;
    logic [7:0]  r_status;
    logic [7:0]  r_dx;
    logic [7:0]  r_dy;
    logic        r_int;

    assign w_accept = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    assign w_bad    = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);

`ifdef MOUSE_SM_WATCHDOG_EN
    assign w_wd_active = is_watchdog_state(r_state);
`else
    assign w_wd_active = 1'b0;
`endif

    // One timer serves both the power-up wait and the watchdog; the two never
    // run in the same state, so the terminal value follows the state.
    assign w_terminal = (r_state == ST_INIT) ? c_init_tc : c_wd_tc;
    assign w_count_en = (r_state == ST_INIT) || w_wd_active;
    // Restart on every state change, and hold at zero while not counting so
    // each counting state starts from a clean count.
    assign w_clear    = (w_next != r_state) || !w_count_en;

    mouse_sm_timer #(
        .WIDTH (32)
    ) u_timer (
        .clk        (CLK),
        .rst        (RESET),
        .i_load     (w_clear),
        .i_load_val (32'd0),
        .i_en       (w_count_en),
        .i_terminal (w_terminal),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:          if (w_tc) w_next = ST_SEND_RST;
            ST_SEND_RST:      w_next = ST_WAIT_RST_SENT;
            ST_WAIT_RST_SENT: if (BYTE_SENT) w_next = ST_WAIT_ACK1;
            ST_WAIT_ACK1: begin
                if (BYTE_READY)
                    w_next = (w_accept && BYTE_READ == RSP_ACK) ?
                             ST_WAIT_SELFTEST : ST_INIT;
            end
            ST_WAIT_SELFTEST: begin
                if (BYTE_READY)
                    w_next = (w_accept && BYTE_READ == RSP_SELFTEST_OK) ?
                             ST_WAIT_ID : ST_INIT;
            end
            ST_WAIT_ID: begin
                if (BYTE_READY)
                    w_next = (w_accept && BYTE_READ == RSP_DEV_ID) ?
                             ST_SEND_EN : ST_INIT;
            end
            ST_SEND_EN:       w_next = ST_WAIT_EN_SENT;
            ST_WAIT_EN_SENT:  if (BYTE_SENT) w_next = ST_WAIT_ACK2;
            ST_WAIT_ACK2: begin
                // Some mice echo the command instead of acknowledging it
                if (BYTE_READY)
                    w_next = (w_accept && (BYTE_READ == RSP_ACK ||
                                           BYTE_READ == CMD_STREAM_EN)) ?
                             ST_RD_STATUS : ST_INIT;
            end
            ST_RD_STATUS: begin
                if (w_bad)         w_next = ST_INIT;
                else if (w_accept) w_next = ST_RD_DX;
            end
            ST_RD_DX: begin
                if (w_bad)         w_next = ST_INIT;
                else if (w_accept) w_next = ST_RD_DY;
            end
            ST_RD_DY: begin
                if (w_bad)         w_next = ST_INIT;
                else if (w_accept) w_next = ST_PUBLISH;
            end
            ST_PUBLISH:       w_next = ST_RD_STATUS;
            default:          w_next = ST_INIT;
        endcase
        // Watchdog expiry overrides whatever the mouse did this cycle
        if (w_wd_active && w_tc) w_next = ST_INIT;
    end

    // Outputs are decoded from the next state so that each registered output
    // is valid in the same cycle as the state it belongs to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= ST_INIT;
            r_send_byte    <= 1'b0;
            r_byte_to_send <= 8'h00;
            r_read_en      <= 1'b0;
            r_sh_status    <= 8'h00;
            r_sh_dx        <= 8'h00;
            r_status       <= 8'h00;
            r_dx           <= 8'h00;
            r_dy           <= 8'h00;
            r_int          <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_send_byte <= (w_next == ST_SEND_RST) || (w_next == ST_SEND_EN);
            if (w_next == ST_SEND_RST)
                r_byte_to_send <= CMD_RESET;
            else if (w_next == ST_SEND_EN)
                r_byte_to_send <= CMD_STREAM_EN;
            r_read_en <= is_read_state(w_next);
            r_int     <= (w_next == ST_PUBLISH);

            if (r_state == ST_RD_STATUS && w_accept)
                r_sh_status <= BYTE_READ;
            if (r_state == ST_RD_DX && w_accept)
                r_sh_dx <= BYTE_READ;

            // The DY byte goes straight from the receiver to the output so
            // the packet lands in the same cycle as the interrupt pulse.
            if (w_next == ST_PUBLISH) begin
                r_status <= r_sh_status;
                r_dx     <= r_sh_dx;
                r_dy     <= BYTE_READ;
            end
        end
    end

    assign SEND_BYTE      = r_send_byte;
    assign BYTE_TO_SEND   = r_byte_to_send;
    assign READ_ENABLE    = r_read_en;
    assign MOUSE_STATUS   = r_status;
    assign MOUSE_DX       = r_dx;
    assign MOUSE_DY       = r_dy;
    assign SEND_INTERRUPT = r_int;
    assign CURR_STATE     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mouse_master_sm.sv
//============================================================================
// Module      : tb_mouse_master_sm
// Description : Directed self-checking bench for mouse_master_sm.
// Config      : MOUSE_SM_WATCHDOG_EN selects the watchdog expectation.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mouse_master_sm;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;
    logic [3:0] CURR_STATE;

    int n_checks = 0;
    int n_errors = 0;

    mouse_master_sm #(
        .INIT_WAIT_CYCLES (100),
        .WATCHDOG_CYCLES  (50)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SEND_BYTE       (SEND_BYTE),
        .BYTE_TO_SEND    (BYTE_TO_SEND),
        .BYTE_SENT       (BYTE_SENT),
        .READ_ENABLE     (READ_ENABLE),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY),
        .MOUSE_STATUS    (MOUSE_STATUS),
        .MOUSE_DX        (MOUSE_DX),
        .MOUSE_DY        (MOUSE_DY),
        .SEND_INTERRUPT  (SEND_INTERRUPT),
        .CURR_STATE      (CURR_STATE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 ns after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_sent();
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic [1:0] err);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = err;
        BYTE_READY      = 1'b1;
        tick();
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    // Called in the first cycle of state 0: 100 cycles in state 0, then the
    // reset command goes out for one cycle.
    task automatic init_wait(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 99; i++) begin
            tick();
            if (CURR_STATE != 4'd0) ok = 1'b0;
        end
        check({tag, "_hold0"}, 8'(ok), 8'h01);
        tick();
        check({tag, "_state1"}, 8'(CURR_STATE), 8'd1);
        check({tag, "_send"}, 8'(SEND_BYTE), 8'h01);
        check({tag, "_cmd"}, BYTE_TO_SEND, 8'hFF);
        tick();
        check({tag, "_state2"}, 8'(CURR_STATE), 8'd2);
        check({tag, "_send_off"}, 8'(SEND_BYTE), 8'h00);
    endtask

    // From state 2 through to state 9, with the given stream-enable ack
    task automatic handshake(input string tag, input logic [7:0] ack2);
        pulse_sent();
        rx_byte(8'hFA, 2'b00);
        rx_byte(8'hAA, 2'b00);
        rx_byte(8'h00, 2'b00);
        check({tag, "_en_state"}, 8'(CURR_STATE), 8'd6);
        check({tag, "_en_send"}, 8'(SEND_BYTE), 8'h01);
        check({tag, "_en_cmd"}, BYTE_TO_SEND, 8'hF4);
        tick();
        check({tag, "_en_hold"}, BYTE_TO_SEND, 8'hF4);
        pulse_sent();
        rx_byte(ack2, 2'b00);
        check({tag, "_stream"}, 8'(CURR_STATE), 8'd9);
    endtask

    task automatic packet(input string tag, input logic [7:0] s,
                          input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] prev_dy);
        rx_byte(s, 2'b00);
        rx_byte(x, 2'b00);
        check({tag, "_dy_held"}, MOUSE_DY, prev_dy);
        check({tag, "_no_int"}, 8'(SEND_INTERRUPT), 8'h00);
        rx_byte(y, 2'b00);
        check({tag, "_pub_state"}, 8'(CURR_STATE), 8'd12);
        check({tag, "_int"}, 8'(SEND_INTERRUPT), 8'h01);
        check({tag, "_status"}, MOUSE_STATUS, s);
        check({tag, "_dx"}, MOUSE_DX, x);
        check({tag, "_dy"}, MOUSE_DY, y);
        tick();
        check({tag, "_int_off"}, 8'(SEND_INTERRUPT), 8'h00);
        check({tag, "_back9"}, 8'(CURR_STATE), 8'd9);
        check({tag, "_dy_keep"}, MOUSE_DY, y);
    endtask

    initial begin
        RESET           = 1'b1;
        BYTE_SENT       = 1'b0;
        BYTE_READ       = 8'h00;
        BYTE_ERROR_CODE = 2'b00;
        BYTE_READY      = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_state", 8'(CURR_STATE), 8'd0);
        check("rst_send", 8'(SEND_BYTE), 8'h00);
        check("rst_cmd", BYTE_TO_SEND, 8'h00);
        check("rst_rden", 8'(READ_ENABLE), 8'h00);
        check("rst_int", 8'(SEND_INTERRUPT), 8'h00);
        check("rst_status", MOUSE_STATUS, 8'h00);
        RESET = 1'b0;

        init_wait("pwr");

        // Receiver is off in state 2: a stray byte is ignored
        check("s2_rden", 8'(READ_ENABLE), 8'h00);
        rx_byte(8'hFA, 2'b00);
        check("s2_ignore_rx", 8'(CURR_STATE), 8'd2);
        pulse_sent();
        check("s3_rden", 8'(READ_ENABLE), 8'h01);
        // Transmitter done while waiting for the ack is ignored
        pulse_sent();
        check("s3_ignore_sent", 8'(CURR_STATE), 8'd3);
        rx_byte(8'hFA, 2'b00);
        rx_byte(8'hAA, 2'b00);
        rx_byte(8'h00, 2'b00);
        check("en_state", 8'(CURR_STATE), 8'd6);
        check("en_send", 8'(SEND_BYTE), 8'h01);
        check("en_cmd", BYTE_TO_SEND, 8'hF4);
        tick();
        check("en_sent_state", 8'(CURR_STATE), 8'd7);
        check("en_send_off", 8'(SEND_BYTE), 8'h00);
        pulse_sent();
        rx_byte(8'hFA, 2'b00);
        check("stream_state", 8'(CURR_STATE), 8'd9);
        check("stream_rden", 8'(READ_ENABLE), 8'h01);

        packet("pkt1", 8'h09, 8'h05, 8'hFB, 8'h00);
        packet("pkt2", 8'h28, 8'hFF, 8'h01, 8'hFB);

        // Receiver error on the DX byte: back to init, old packet kept
        rx_byte(8'h08, 2'b00);
        rx_byte(8'h33, 2'b10);
        check("err_state", 8'(CURR_STATE), 8'd0);
        check("err_no_int", 8'(SEND_INTERRUPT), 8'h00);
        check("err_rden", 8'(READ_ENABLE), 8'h00);
        check("err_status", MOUSE_STATUS, 8'h28);
        check("err_dx", MOUSE_DX, 8'hFF);
        check("err_dy", MOUSE_DY, 8'h01);
        init_wait("err");

        // Wrong self-test result restarts the init wait
        pulse_sent();
        rx_byte(8'hFA, 2'b00);
        check("st_state4", 8'(CURR_STATE), 8'd4);
        rx_byte(8'hFC, 2'b00);
        check("st_bad", 8'(CURR_STATE), 8'd0);
        init_wait("st");

        // Echoed enable command accepted as the stream-mode ack
        handshake("echo", 8'hF4);
        packet("pkt3", 8'h18, 8'h80, 8'h7F, 8'h01);

        // Reset in the middle of a packet
        rx_byte(8'h09, 2'b00);
        check("mid_state10", 8'(CURR_STATE), 8'd10);
        RESET = 1'b1;
        tick();
        check("mid_rst_state", 8'(CURR_STATE), 8'd0);
        check("mid_rst_status", MOUSE_STATUS, 8'h00);
        check("mid_rst_dy", MOUSE_DY, 8'h00);
        check("mid_rst_cmd", BYTE_TO_SEND, 8'h00);
        RESET = 1'b0;
        init_wait("mid");
        handshake("wd", 8'hFA);

        // Idle in stream mode
        begin
            logic ok;
            ok = 1'b1;
            for (int i = 0; i < 49; i++) begin
                tick();
                if (CURR_STATE != 4'd9) ok = 1'b0;
            end
            check("idle_hold9", 8'(ok), 8'h01);
            tick();
`ifdef MOUSE_SM_WATCHDOG_EN
            check("wd_expire", 8'(CURR_STATE), 8'd0);
`else
            check("no_wd_50", 8'(CURR_STATE), 8'd9);
            for (int i = 0; i < 30; i++) tick();
            check("no_wd_80", 8'(CURR_STATE), 8'd9);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
